cpu_fetch: RTL
==============

Name: cpu_fetch

Overview:
- Instruction-fetch stage of the CPU pipeline, directly upstream of the hazard/stall unit.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Presents the fetched word on if_instr, which the stall unit decodes.
- Consumes rw_stall/jb_stall from the stall unit and a branch redirect from execute; buffers a response that arrives while stalled.

Parameters:
- PC_W, 32, PC/address width in bits (byte address).
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0000, bubble word driven on if_instr (opcode 8'h00 is neither L nor R type).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rw_stall  in  1  hold the fetch output (register read-after-write hazard)
- jb_stall  in  1  jump/branch in flight; inject bubbles
- br_taken  in  1  redirect pulse from execute
- br_target  in  PC_W  redirect address
- imem_req  out  1  request valid
- imem_addr  out  PC_W  request address (= pc)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  response instruction
- if_instr  out  32  instruction to decode and the stall unit
- if_pc  out  PC_W  PC of if_instr
- if_valid  out  1  if_instr is a real instruction, not a bubble

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC, state=FETCH, skid empty.
  - if_instr=NOP_INSTR, if_pc=0, if_valid=0, imem_req=0.
  - Reset mid-request abandons it; any rvalid in the cycle after reset is dropped.
- States:
  - FETCH: imem_req=1 when no stall is asserted.
    - imem_gnt -> WAIT.
    - If rw_stall or jb_stall=1, drive imem_req=0 and stay.
  - WAIT: await imem_rvalid.
    - If rw_stall=0: load output register (if_instr=rdata, if_pc=pc, if_valid=1), pc+=4 -> FETCH.
    - If rw_stall=1: write rdata/pc into skid, pc+=4 -> HOLD.
  - HOLD: skid full.
    - When rw_stall=0: skid -> output register, skid cleared -> FETCH.
  - FLUSH: a redirect occurred with a request in flight.
    - Next imem_rvalid is discarded -> FETCH.
- Output register priority (per cycle, highest first):
  1. br_taken: pc=br_target with bits[1:0] forced 0; if_instr=NOP_INSTR, if_valid=0; skid cleared.
     - From WAIT without rvalid -> FLUSH.
     - From WAIT with rvalid in the same cycle -> data dropped -> FETCH.
     - From any other state -> FETCH.
  2. rw_stall=1: output register holds all fields. rw_stall wins over jb_stall when both are asserted.
  3. jb_stall=1: output register loads NOP_INSTR with if_valid=0 each cycle. The pc holds; no new request is issued. A response already in flight is captured into the skid (state HOLD) and released after jb_stall drops.
  4. Otherwise: normal advance as described under States.
- Latency: first if_valid occurs 2 cycles after rst drops when imem grants immediately and returns rvalid one cycle later.
- Throughput: best case one instruction per 2 cycles (single outstanding request).
- Arithmetic: pc increments by 4 modulo 2^PC_W; wrap from all-ones-minus-3 to 0 is legal.
- imem_addr=pc and imem_req are combinational from state/stall and stable while waiting for gnt.

Optional Feature:
- Macro: CPU_FETCH_PERF_EN.
- When defined, adds three 32-bit saturating counters:
  - perf_rw_cycles: counts cycles with rw_stall=1.
  - perf_jb_bubbles: counts bubbles injected due to jb_stall.
  - perf_redirects: counts br_taken pulses.
- Adds outputs perf_rw_cycles, perf_jb_bubbles, perf_redirects, each 32 bits.
- Counters clear on rst.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch_state_t enum {FETCH, WAIT, HOLD, FLUSH}.
  - NOP_INSTR default.
  - Opcode constants shared with the stall unit and decode.
- One sub-module, cpu_fetch_skid: 1-entry {instr, pc} buffer with load/unload/clear.

Test Plan:
- Reset release, imem grants at once with 1-cycle rvalid, rdata=32'h1000_0000 -> if_valid=1, if_pc=0, if_instr=32'h1000_0000 by cycle 2; next imem_addr=4.
- rvalid arrives during rw_stall=1 for 3 cycles -> if_* unchanged for 3 cycles, skid holds the word, imem_req=0; word appears in the cycle after rw_stall drops.
- jb_stall=1 for 2 cycles -> two outputs with if_instr=0 and if_valid=0, pc unchanged, then fetch resumes at the held pc.
- br_taken with br_target=32'h0000_0102 while in WAIT, rvalid one cycle later -> that response is dropped, next imem_addr=32'h0000_0100, if_valid=0 until the new word arrives.
- Simultaneous br_taken and rw_stall -> redirect wins: pc=target, skid cleared, bubble output.
- RESET_PC=32'hFFFF_FFFC, one fetch -> next imem_addr=0 (wrap).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: fetch FSM states, the bubble word and opcode constants.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // free to issue a request at pc
        WAIT  = 2'd1,   // request granted, response owed
        HOLD  = 2'd2,   // response parked in the skid while downstream is stalled
        FLUSH = 2'd3    // redirected with a response still owed; it will be discarded
    } fetch_state_t;

    // Opcode lives in the top byte of the instruction word.
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 24;

    // Opcode classes the stall unit and decode key on. 8'h00 is neither L nor R
    // type, so an all-zero word passes through the stall unit as a harmless bubble.
    localparam logic [7:0] OPC_NOP    = 8'h00;
    localparam logic [7:0] OPC_L_TYPE = 8'h10;
    localparam logic [7:0] OPC_R_TYPE = 8'h20;

    localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0000;

    function automatic logic [7:0] instr_opcode(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/cpu_fetch_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// Latency: n/a (wires only); the memory may grant and respond on any later cycle.
// Backpressure: imem_req is held with a stable imem_addr until imem_gnt; one request outstanding.
// Ports: imem_req/imem_addr (fetch -> mem), imem_gnt/imem_rvalid/imem_rdata (mem -> fetch).
interface cpu_fetch_if #(
    parameter int PC_W = 32
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/cpu_fetch_skid.sv
// One-entry {instr, pc} buffer holding a fetched word while the fetch output is stalled.
// Latency: load visible on the cycle after load_i; unload/clear empty it the cycle after.
// Backpressure: none internally; the owner loads only when empty and unloads when released.
// Ports: clk/rst, load_i/unload_i/clear_i, instr_i/pc_i in, full_o/instr_o/pc_o out.
module cpu_fetch_skid #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            unload_i,
    input  logic            clear_i,
    input  logic [31:0]     instr_i,
    input  logic [PC_W-1:0] pc_i,
    output logic            full_o,
    output logic [31:0]     instr_o,
    output logic [PC_W-1:0] pc_o
);

    logic            full_q;
    logic [31:0]     instr_q;
    logic [PC_W-1:0] pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q  <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (clear_i || unload_i) begin
            full_q <= 1'b0;
        end else if (load_i) begin
            full_q  <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign full_o  = full_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/cpu_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests, registers if_*.
// Latency: if_* registered; first valid word 2 cycles after reset with gnt at once and rvalid next cycle.
// Backpressure: rw_stall holds if_*, jb_stall injects bubbles; a response arriving under either parks in the skid.
// Ports: clk/rst; rw_stall, jb_stall, br_taken/br_target in; imem (cpu_fetch_if.master);
//        if_instr/if_pc/if_valid out. Build option CPU_FETCH_PERF_EN adds perf_rw_cycles,
//        perf_jb_bubbles, perf_redirects (32-bit saturating event counters).
module cpu_fetch
    import cpu_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = CPU_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rw_stall,
    input  logic            jb_stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    cpu_fetch_if.master     imem,
    output logic [31:0]     if_instr,
    output logic [PC_W-1:0] if_pc,
    output logic            if_valid
`ifdef CPU_FETCH_PERF_EN
    ,
    output logic [31:0]     perf_rw_cycles,
    output logic [31:0]     perf_jb_bubbles,
    output logic [31:0]     perf_redirects
`endif
);

    localparam logic [PC_W-1:0] PC_INC = PC_W'(4);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic [PC_W-1:0] out_pc_q, out_pc_d;
    logic            out_vld_q, out_vld_d;

    logic            skid_load, skid_unload, skid_clear, skid_full;
    logic [31:0]     skid_instr;
    logic [PC_W-1:0] skid_pc;
    logic            stall_any;
    logic            req;

    // Targets are word aligned; the low bits of br_target are ignored.
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^br_target[1:0];

    assign stall_any = rw_stall | jb_stall;

    // A redirect also suppresses the request so no grant can be taken for the stale pc.
    assign req = !rst && (state_q == FETCH) && !stall_any && !br_taken;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;

    cpu_fetch_skid #(.PC_W(PC_W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .instr_i  (imem.imem_rdata),
        .pc_i     (pc_q),
        .full_o   (skid_full),
        .instr_o  (skid_instr),
        .pc_o     (skid_pc)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        out_vld_d   = out_vld_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        if (br_taken) begin
            pc_d        = {br_target[PC_W-1:2], 2'b00};
            out_instr_d = NOP_INSTR;
            out_vld_d   = 1'b0;
            skid_clear  = 1'b1;
            // A response still owed must be swallowed, or it would be taken as the target's word.
            if ((state_q == WAIT || state_q == FLUSH) && !imem.imem_rvalid) begin
                state_d = FLUSH;
            end else begin
                state_d = FETCH;
            end
        end else begin
            // Every cycle not delivering a word is a bubble, unless the output is being held.
            if (!rw_stall) begin
                out_instr_d = NOP_INSTR;
                out_vld_d   = 1'b0;
            end

            case (state_q)
                FETCH: begin
                    if (req && imem.imem_gnt) state_d = WAIT;
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        pc_d = pc_q + PC_INC;
                        if (stall_any) begin
                            skid_load = 1'b1;
                            state_d   = HOLD;
                        end else begin
                            out_instr_d = imem.imem_rdata;
                            out_pc_d    = pc_q;
                            out_vld_d   = 1'b1;
                            state_d     = FETCH;
                        end
                    end
                end
                HOLD: begin
                    if (!stall_any) begin
                        if (skid_full) begin
                            out_instr_d = skid_instr;
                            out_pc_d    = skid_pc;
                            out_vld_d   = 1'b1;
                        end
                        skid_unload = 1'b1;
                        state_d     = FETCH;
                    end
                end
                FLUSH: begin
                    if (imem.imem_rvalid) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            out_instr_q <= NOP_INSTR;
            out_pc_q    <= '0;
            out_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_vld_q   <= out_vld_d;
        end
    end

    assign if_instr = out_instr_q;
    assign if_pc    = out_pc_q;
    assign if_valid = out_vld_q;

`ifdef CPU_FETCH_PERF_EN
    logic [31:0] perf_rw_q, perf_jb_q, perf_br_q;
    logic        jb_bubble;

    // A jb bubble is only injected when neither a redirect nor a hold overrides it.
    assign jb_bubble = jb_stall && !rw_stall && !br_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_rw_q <= '0;
            perf_jb_q <= '0;
            perf_br_q <= '0;
        end else begin
            if (rw_stall && (perf_rw_q != '1)) perf_rw_q <= perf_rw_q + 32'd1;
            if (jb_bubble && (perf_jb_q != '1)) perf_jb_q <= perf_jb_q + 32'd1;
            if (br_taken && (perf_br_q != '1)) perf_br_q <= perf_br_q + 32'd1;
        end
    end

    assign perf_rw_cycles  = perf_rw_q;
    assign perf_jb_bubbles = perf_jb_q;
    assign perf_redirects  = perf_br_q;
`endif

endmodule
